// File: rtl/pipe_hazard_arbiter.sv
// Fixed-priority hazard arbiter driving per-stage stall/flush vectors, with a
// release pulse, per-source stall counters, a stall watchdog and a stats clear.
module pipe_hazard_arbiter #(
  parameter int NSTAGE = 6,
  parameter int NREQ   = 9,
  parameter logic [NREQ*NSTAGE-1:0] STALL_MASKS = {
    6'b000010, 6'b000011, 6'b000111, 6'b000010, 6'b111111,
    6'b000010, 6'b000011, 6'b001111, 6'b001111},
  parameter logic [NREQ*NSTAGE-1:0] FLUSH_MASKS = {
    6'b000010, 6'b000100, 6'b001000, 6'b000110, 6'b001110,
    6'b001110, 6'b000000, 6'b000000, 6'b010000},
  parameter logic [NREQ-1:0] REL_MASK = 9'b000000001,
  parameter int CW         = 32,
  parameter int WDOG_LIMIT = 1024,
  parameter int WDW        = 16,
  localparam int IDXW      = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_i,
  input  logic              clr_i,
  input  logic [IDXW-1:0]   cnt_sel_i,
  output logic [NSTAGE-1:0] stall_o,
  output logic [NSTAGE-1:0] flush_o,
  output logic              active_o,
  output logic [IDXW-1:0]   win_idx_o,
  output logic              release_o,
  output logic [CW-1:0]     cnt_o,
  output logic              hang_o
);

  function automatic logic [CW-1:0] sat_inc_cnt(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic [WDW-1:0] sat_inc_run(input logic [WDW-1:0] v);
    return (v == {WDW{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic [NREQ-1:0]   req_q;
  logic [CW-1:0]     cnt_q [NREQ];
  logic [CW-1:0]     cnt_d [NREQ];
  logic [WDW-1:0]    run_q, run_d;
  logic              hang_q, hang_d;
  logic [IDXW-1:0]   win_c;
  logic              any_c, rel_c;
  logic [NSTAGE-1:0] stall_c, flush_c;
  logic              active_c;
  logic [IDXW-1:0]   win_out_c;

  // Lowest set index wins; scanning downward leaves the lowest one last.
  always_comb begin
    win_c = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_i[i]) win_c = IDXW'(i);
    end
  end

  assign any_c = |req_i;
  assign rel_c = |(REL_MASK & req_q & ~req_i);

  always_comb begin
    stall_c   = '0;
    flush_c   = '0;
    active_c  = 1'b0;
    win_out_c = '0;
    if (rst) begin
      flush_c = {NSTAGE{1'b1}};
    end else if (!rel_c && any_c) begin
      active_c  = 1'b1;
      win_out_c = win_c;
      for (int i = 0; i < NREQ; i++) begin
        if (win_c == IDXW'(i)) begin
          stall_c = STALL_MASKS[i*NSTAGE +: NSTAGE];
          flush_c = FLUSH_MASKS[i*NSTAGE +: NSTAGE];
        end
      end
    end
  end

  assign stall_o   = stall_c;
  assign flush_o   = flush_c;
  assign active_o  = active_c;
  assign win_idx_o = win_out_c;
  assign release_o = rel_c && !rst;
  assign hang_o    = hang_q;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr_i)
        cnt_d[i] = '0;
      else if (active_c && win_c == IDXW'(i))
        cnt_d[i] = sat_inc_cnt(cnt_q[i]);
    end
  end

  // Run counter tracks consecutive stalled cycles; hang latches on reaching the limit.
  always_comb begin
    run_d  = (stall_c != '0) ? sat_inc_run(run_q) : '0;
    hang_d = hang_q || (WDOG_LIMIT != 0 && run_d == WDW'(WDOG_LIMIT));
    if (clr_i) begin
      run_d  = '0;
      hang_d = 1'b0;
    end
  end

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (cnt_sel_i == IDXW'(i)) cnt_o = cnt_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q  <= '0;
      run_q  <= '0;
      hang_q <= 1'b0;
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else begin
      req_q  <= req_i;
      run_q  <= run_d;
      hang_q <= hang_d;
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: tb/tb_pipe_hazard_arbiter.sv
// Scoreboard bench for pipe_hazard_arbiter: directed scenarios followed by
// random traffic, checked against a cycle-level behavioural model.
module tb_pipe_hazard_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] req = '0;
  logic       clr = 1'b0;
  logic [3:0] sel = '0;
  logic [5:0] stall, flush;
  logic       active, rel_o, hang;
  logic [3:0] win, cnt;

  pipe_hazard_arbiter #(.CW(4), .WDOG_LIMIT(8)) dut (
    .clk(clk), .rst(rst), .req_i(req), .clr_i(clr), .cnt_sel_i(sel),
    .stall_o(stall), .flush_o(flush), .active_o(active), .win_idx_o(win),
    .release_o(rel_o), .cnt_o(cnt), .hang_o(hang)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] st;
    logic [5:0] fl;
    logic       act;
    logic [3:0] win;
    logic       rel;
    logic [3:0] cnt;
    logic       hang;
  } obs_t;

  obs_t  expq[$];
  string tagq[$];
  int    checks = 0;
  int    errors = 0;

  // Source table: index 0 = mem-ram ... 8 = compress.
  logic [5:0] t_stall [9] = '{6'b001111, 6'b001111, 6'b000011, 6'b000010, 6'b111111,
                              6'b000010, 6'b000111, 6'b000011, 6'b000010};
  logic [5:0] t_flush [9] = '{6'b010000, 6'b000000, 6'b000000, 6'b001110, 6'b001110,
                              6'b000110, 6'b001000, 6'b000100, 6'b000010};
  logic [8:0] rel_src = 9'b000000001;
  int CNT_MAX = 15;
  int RUN_MAX = 65535;
  int LIMIT   = 8;

  logic [8:0] m_prev;
  int         m_cnt [9];
  int         m_run;
  logic       m_hang;

  task automatic cyc(input logic r, input logic [8:0] rq, input logic c,
                     input logic [3:0] s, input string tag);
    obs_t e;
    logic rl;
    int   w;
    @(posedge clk);
    #1;
    rst = r; req = rq; clr = c; sel = s;
    e = '0;
    if (r) begin
      e.fl = 6'b111111;
      m_prev = '0; m_run = 0; m_hang = 1'b0;
      for (int i = 0; i < 9; i++) m_cnt[i] = 0;
    end else begin
      rl = 1'b0;
      for (int i = 0; i < 9; i++)
        if (rel_src[i] && m_prev[i] && !rq[i]) rl = 1'b1;
      w = -1;
      for (int i = 0; i < 9; i++)
        if (rq[i] && w < 0) w = i;
      e.cnt  = (s < 9) ? 4'(m_cnt[s]) : 4'd0;
      e.hang = m_hang;
      if (rl) begin
        e.rel = 1'b1;
      end else if (w >= 0) begin
        e.st = t_stall[w]; e.fl = t_flush[w]; e.act = 1'b1; e.win = 4'(w);
      end
      if (c) begin
        for (int i = 0; i < 9; i++) m_cnt[i] = 0;
        m_run = 0; m_hang = 1'b0;
      end else begin
        if (e.act && m_cnt[w] < CNT_MAX) m_cnt[w] = m_cnt[w] + 1;
        if (e.st != 0) m_run = (m_run < RUN_MAX) ? m_run + 1 : RUN_MAX;
        else m_run = 0;
        if (m_run == LIMIT) m_hang = 1'b1;
      end
      m_prev = rq;
    end
    expq.push_back(e);
    tagq.push_back(tag);
  endtask

  // Monitor: every cycle the DUT presents a full output set; compare mid-cycle.
  initial begin
    obs_t  a, e;
    string t;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        t = tagq.pop_front();
        a.st = stall; a.fl = flush; a.act = active; a.win = win;
        a.rel = rel_o; a.cnt = cnt; a.hang = hang;
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL %s: got st=%b fl=%b act=%b win=%0d rel=%b cnt=%0d hang=%b, want st=%b fl=%b act=%b win=%0d rel=%b cnt=%0d hang=%b",
                   t, a.st, a.fl, a.act, a.win, a.rel, a.cnt, a.hang,
                   e.st, e.fl, e.act, e.win, e.rel, e.cnt, e.hang);
        end
      end
    end
  end

  initial begin
    m_prev = '0; m_run = 0; m_hang = 1'b0;
    for (int i = 0; i < 9; i++) m_cnt[i] = 0;

    cyc(1, 9'h1FF, 0, 4'd0, "reset");
    cyc(1, 9'h1FF, 0, 4'd6, "reset");
    cyc(0, 9'h000, 0, 4'd0, "post_reset");

    cyc(0, 9'b110100000, 0, 4'd5, "prio_jump");
    cyc(0, 9'b110000000, 0, 4'd7, "prio_loaduse");

    cyc(0, 9'h000, 1, 4'd0, "rel_clr");
    for (int k = 0; k < 3; k++) cyc(0, 9'h081, 0, 4'd0, "rel_hold");
    cyc(0, 9'h080, 0, 4'd0, "rel_pulse");
    cyc(0, 9'h080, 0, 4'd7, "rel_after");
    cyc(0, 9'h001, 0, 4'd0, "b2b_high");
    cyc(0, 9'h080, 0, 4'd0, "b2b_low");
    cyc(0, 9'h001, 0, 4'd0, "b2b_again");

    cyc(0, 9'h000, 1, 4'd6, "cnt_clr");
    for (int k = 0; k < 10; k++) cyc(0, 9'h040, 0, 4'd6, "cnt_hold");
    cyc(0, 9'h000, 0, 4'd6, "cnt_ten");
    cyc(0, 9'h040, 1, 4'd6, "cnt_clr_wins");
    cyc(0, 9'h000, 0, 4'd6, "cnt_zero");
    cyc(0, 9'h000, 0, 4'd12, "cnt_sel_oob");

    cyc(0, 9'h000, 1, 4'd4, "wd_clr");
    for (int k = 0; k < 8; k++) cyc(0, 9'h010, 0, 4'd4, "wd_hold");
    for (int k = 0; k < 3; k++) cyc(0, 9'h000, 0, 4'd4, "wd_sticky");
    cyc(0, 9'h000, 1, 4'd4, "wd_clr2");
    cyc(0, 9'h000, 0, 4'd4, "wd_cleared");

    for (int k = 0; k < 20; k++) cyc(0, 9'h100, 0, 4'd8, "sat_hold");
    cyc(0, 9'h000, 0, 4'd8, "sat_15");

    cyc(0, 9'h011, 0, 4'd0, "rst_mid");
    cyc(1, 9'h011, 0, 4'd0, "rst_mid_on");
    cyc(0, 9'h000, 0, 4'd0, "rst_no_rel");

    for (int k = 0; k < 600; k++) begin
      logic [8:0] rq;
      rq = 9'($urandom) & 9'($urandom);
      if ($urandom_range(0, 7) == 0) rq = '0;
      cyc(($urandom_range(0, 79) == 0), rq, ($urandom_range(0, 23) == 0),
          4'($urandom_range(0, 15)), "random");
    end

    repeat (3) @(posedge clk);
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
